// File: rtl/arb_pkg.sv
// ----------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the instruction-memory port arbiter:
//   - owner_e          : who currently drives the memory port (fetch or data)
//   - DATA_MAX_DEFAULT : default bound on unlocked data beats while fetch waits
//   - hold_cnt_width() : width of the saturating hold counter for a given bound
// ----------------------------------------------------------------------------
package arb_pkg;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    localparam int DATA_MAX_DEFAULT = 4;

    // One extra bit beyond clog2 so the counter can hold DATA_MAX-1 and still
    // keep counting during long locked bursts before it saturates.
    function automatic int hold_cnt_width(input int data_max);
        return $clog2(data_max) + 1;
    endfunction

endpackage : arb_pkg

// File: rtl/arb_hold_ctr.sv
// ----------------------------------------------------------------------------
// arb_hold_ctr
// Saturating up-counter that tracks how many consecutive data beats have been
// granted in the current data tenure.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clr      : clear to zero (wins over i_inc)
//   i_inc      : increment by one, holding at the all-ones value
//   o_ge       : counter value >= THRESH
// ----------------------------------------------------------------------------
module arb_hold_ctr #(
    parameter int W      = 3,
    parameter int THRESH = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_ge
);

    localparam logic [W-1:0] CNT_MAX  = '1;
    localparam logic [W-1:0] THRESH_V = W'(THRESH);

    logic [W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its inputs, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_ge = (r_cnt >= THRESH_V);

endmodule : arb_hold_ctr

// File: rtl/imem_port_arbiter.sv
// ----------------------------------------------------------------------------
// imem_port_arbiter
// Shares one byte-wide memory port (async read, sync write) between the
// instruction fetch stage (read-only) and the data unit (loads/stores with
// optional locked bursts). Data has priority; a hold counter bounds how many
// unlocked data beats may pass while fetch is waiting.
//
// Ports
//   clk, rst_n                  : clock, asynchronous active-low reset
//   if_req/if_addr              : fetch read request and byte address
//   if_gnt/if_rdata             : fetch beat accepted / read data
//   d_req/d_we/d_addr/d_wdata   : data request, write enable, address, data
//   d_lock                      : keep ownership across beats (burst)
//   d_gnt/d_rdata               : data beat accepted / read data
//   mem_addr/mem_wdata/mem_we   : memory address, write data, write enable
//   mem_rdata                   : asynchronous memory read data
//   owner_d                     : current owner (0 = fetch, 1 = data)
// ----------------------------------------------------------------------------
module imem_port_arbiter
    import arb_pkg::*;
#(
    parameter int AW       = 16,
    parameter int DATA_MAX = DATA_MAX_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic [7:0]    if_rdata,

    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [7:0]    d_wdata,
    input  logic          d_lock,
    output logic          d_gnt,
    output logic [7:0]    d_rdata,

    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    output logic          mem_we,
    input  logic [7:0]    mem_rdata,

    output logic          owner_d
);

    localparam int CW = hold_cnt_width(DATA_MAX);

    owner_e r_owner;
    owner_e w_owner_nxt;
    logic   w_cnt_clr;
    logic   w_cnt_inc;
    logic   w_hold_ge;

    // ------------------------------------------------------------------
    // Owner register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner <= OWN_IF;
        end else begin
            r_owner <= w_owner_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-owner and hold-counter control
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        w_owner_nxt = r_owner;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;

        unique case (r_owner)
            OWN_IF: begin
                // Counter is held at zero while fetch owns, so a new data
                // tenure always starts counting from zero. d_lock is ignored.
                w_cnt_clr = 1'b1;
                if (d_req) begin
                    w_owner_nxt = OWN_IF == r_owner ? OWN_D : r_owner;
                end
            end
            OWN_D: begin
                if (d_req) begin
                    // Hand over on this beat only if the burst is unlocked,
                    // fetch is waiting and data has used its allowance.
                    if (!d_lock && if_req && w_hold_ge) begin
                        w_owner_nxt = OWN_IF;
                        w_cnt_clr   = 1'b1;
                    end else begin
                        w_cnt_inc   = 1'b1;
                    end
                end else begin
                    // Data idle: release to a waiting fetch, otherwise park.
                    w_cnt_clr = 1'b1;
                    if (if_req) begin
                        w_owner_nxt = OWN_IF;
                    end
                end
            end
        endcase
    end

    arb_hold_ctr #(
        .W      (CW),
        .THRESH (DATA_MAX - 1)
    ) u_hold_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_cnt_clr),
        .i_inc (w_cnt_inc),
        .o_ge  (w_hold_ge)
    );

    // ------------------------------------------------------------------
    // Grants and memory mux, all decoded from the registered owner so an
    // asynchronous reset drops grants and the write strobe immediately.
    // ------------------------------------------------------------------
    assign if_gnt    = if_req & (r_owner == OWN_IF);
    assign d_gnt     = d_req  & (r_owner == OWN_D);
    assign owner_d   = (r_owner == OWN_D);

    assign mem_addr  = (r_owner == OWN_D) ? d_addr : if_addr;
    assign mem_wdata = d_wdata;
    assign mem_we    = d_gnt & d_we;

    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;

endmodule : imem_port_arbiter

// File: tb/tb_imem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_imem_port_arbiter
// Self-checking bench: directed scenarios (reset, priority switch, starvation
// bound, locked burst, idle bubble, async reset mid-write) followed by
// randomized traffic, all compared against a behavioural ownership model and
// a reference copy of the memory.
// ----------------------------------------------------------------------------
module tb_imem_port_arbiter;

    localparam int AW       = 16;
    localparam int DATA_MAX = 4;
    localparam int MEM_SZ   = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic [7:0]    if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [7:0]    d_wdata;
    logic          d_lock;
    logic          d_gnt;
    logic [7:0]    d_rdata;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          mem_we;
    logic [7:0]    mem_rdata;
    logic          owner_d;

    always #5 clk = ~clk;

    imem_port_arbiter #(.AW(AW), .DATA_MAX(DATA_MAX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_lock    (d_lock),
        .d_gnt     (d_gnt),
        .d_rdata   (d_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .owner_d   (owner_d)
    );

    function automatic logic [7:0] init_byte(input int a);
        return 8'((a * 7) ^ 'h5C);
    endfunction

    // ------------------------------------------------------------------
    // Memory behind the port: async read, write at posedge when mem_we.
    // ------------------------------------------------------------------
    logic [7:0] mem [0:MEM_SZ-1];
    bit         mem_ready = 1'b0;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < MEM_SZ; i++) mem[i] <= init_byte(i);
            mem_ready <= 1'b1;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    assign mem_rdata = mem[mem_addr];

    // ------------------------------------------------------------------
    // Reference model and bookkeeping
    // ------------------------------------------------------------------
    logic [7:0] ref_mem [0:MEM_SZ-1];
    bit         m_own_d;      // model: data currently owns the port
    int         m_run;        // model: data beats in the current busy tenure
    int         n_vec = 0;
    int         n_err = 0;
    bit         g_if, g_d;    // model grants of the previous cycle
    bit         o_if_gnt, o_d_gnt, o_owner;
    logic [AW-1:0] o_addr;
    logic [7:0] o_d_rdata;
    int         d_run_obs = 0;
    int         d_run_max = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Rule set applied at each clock edge: data wins when fetch owns; data keeps
    // the port while busy unless unlocked and it has already had DATA_MAX beats
    // with fetch waiting; idle data yields to waiting fetch or stays parked.
    task automatic model_edge();
        if (!m_own_d) begin
            if (d_req) begin
                m_own_d = 1'b1;
                m_run   = 0;
            end
        end else if (d_req) begin
            if (!d_lock && if_req && (m_run + 1 >= DATA_MAX)) begin
                m_own_d = 1'b0;
                m_run   = 0;
            end else begin
                m_run++;
            end
        end else begin
            m_run = 0;
            if (if_req) m_own_d = 1'b0;
        end
    endtask

    // Checks one cycle at the negedge, then advances the model at the posedge.
    task automatic cycle_check();
        bit e_if, e_d;
        @(negedge clk);
        e_if = if_req && !m_own_d;
        e_d  = d_req && m_own_d;
        o_if_gnt  = if_gnt;
        o_d_gnt   = d_gnt;
        o_owner   = owner_d;
        o_addr    = mem_addr;
        o_d_rdata = d_rdata;
        check("if_gnt",   if_gnt,  e_if);
        check("d_gnt",    d_gnt,   e_d);
        check("owner_d",  owner_d, m_own_d);
        check("mem_we",   mem_we,  e_d && d_we);
        check("mem_addr", mem_addr, m_own_d ? d_addr : if_addr);
        if (e_d && d_we) check("mem_wdata", mem_wdata, d_wdata);
        if (e_if)        check("if_rdata", if_rdata, ref_mem[if_addr]);
        if (e_d && !d_we) check("d_rdata", d_rdata, ref_mem[d_addr]);
        if (d_gnt) d_run_obs++; else d_run_obs = 0;
        if (d_run_obs > d_run_max) d_run_max = d_run_obs;
        @(posedge clk);
        if (e_d && d_we) ref_mem[d_addr] = d_wdata;
        model_edge();
        g_if = e_if;
        g_d  = e_d;
        #1;
    endtask

    // Streaming fetch: advance to the next byte once the current one is taken.
    task automatic fetch_next();
        if (g_if) if_addr = if_addr + 1'b1;
    endtask

    initial begin
        int nb;
        int n_ifg;
        int nbad;
        bit done;

        for (int i = 0; i < MEM_SZ; i++) ref_mem[i] = init_byte(i);
        m_own_d = 1'b0; m_run = 0; g_if = 1'b0; g_d = 1'b0;
        rst_n = 1'b0;
        if_req = 1'b1; if_addr = 16'h0003;
        d_req = 1'b0; d_we = 1'b0; d_lock = 1'b0; d_addr = '0; d_wdata = '0;

        // ---------------- reset ----------------
        #12;
        check("rst_if_gnt",   if_gnt,   1);
        check("rst_d_gnt",    d_gnt,    0);
        check("rst_owner",    owner_d,  0);
        check("rst_mem_we",   mem_we,   0);
        check("rst_mem_addr", mem_addr, 16'h0003);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        cycle_check();
        check("rel_if_gnt", o_if_gnt, 1);

        // ---------------- priority switch ----------------
        if_addr = 16'h0080;
        cycle_check(); fetch_next();
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h1A2B;
        cycle_check(); fetch_next();
        check("sw_n_if_gnt", o_if_gnt, 1);
        cycle_check(); fetch_next();
        check("sw_n1_owner",  o_owner,   1);
        check("sw_n1_d_gnt",  o_d_gnt,   1);
        check("sw_n1_if_gnt", o_if_gnt,  0);
        check("sw_n1_addr",   o_addr,    16'h1A2B);
        check("sw_n1_rdata",  o_d_rdata, init_byte(16'h1A2B));

        // ---------------- starvation bound ----------------
        d_run_max = 0; n_ifg = 0;
        for (int c = 0; c < 25; c++) begin
            cycle_check(); fetch_next();
            if (o_if_gnt) n_ifg++;
        end
        check("starve_max_run", d_run_max, DATA_MAX);
        check("starve_if_beats", n_ifg, 5);

        // Data goes idle: hand back to the streaming fetch.
        d_req = 1'b0;
        cycle_check(); fetch_next();

        // ---------------- locked burst ----------------
        d_req = 1'b1; d_we = 1'b1; d_lock = 1'b1; d_addr = 16'h0010; d_wdata = 8'hA0;
        nb = 0;
        for (int c = 0; c < 20 && nb < 6; c++) begin
            cycle_check(); fetch_next();
            if (g_d) begin
                nb++;
                d_addr  = d_addr + 1'b1;
                d_wdata = d_wdata + 1'b1;
                d_lock  = (nb < 5);
                if (nb == 6) d_req = 1'b0;
            end
        end
        check("lock_beats", nb, 6);
        check("lock_run", d_run_obs, 6);
        d_we = 1'b0; d_lock = 1'b0;
        cycle_check(); fetch_next();
        check("lock_if_after", o_if_gnt, 1);
        for (int i = 0; i < 6; i++) check("lock_mem", mem[16'h0010 + i], 8'hA0 + i);

        // ---------------- idle bubble ----------------
        if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0040;
        cycle_check();
        cycle_check();
        check("park_d_gnt", o_d_gnt, 1);
        d_req = 1'b0;
        cycle_check();
        check("park_owner", o_owner, 1);
        if_req = 1'b1;
        nb = 0; done = 1'b0;
        for (int c = 0; c < 8 && !done; c++) begin
            cycle_check(); fetch_next();
            if (o_if_gnt) done = 1'b1; else nb++;
        end
        check("bubble_granted", done, 1);
        check("bubble_cnt", nb, 1);
        check("bubble_owner", o_owner, 0);

        // ---------------- async reset mid-write ----------------
        if_req = 1'b0; d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0200; d_wdata = 8'h5A;
        done = 1'b0;
        for (int c = 0; c < 8 && !done; c++) begin
            cycle_check();
            if (m_own_d) done = 1'b1;
        end
        check("arst_setup", done, 1);
        #1;
        check("arst_pre_we", mem_we, 1);
        #1 rst_n = 1'b0;
        #2;
        check("arst_mem_we", mem_we,  0);
        check("arst_d_gnt",  d_gnt,   0);
        check("arst_owner",  owner_d, 0);
        m_own_d = 1'b0; m_run = 0; g_if = 1'b0; g_d = 1'b0;
        @(posedge clk); #1;
        check("arst_no_write", mem[16'h0200], init_byte(16'h0200));
        d_req = 1'b0; d_we = 1'b0; rst_n = 1'b1;

        // ---------------- randomized traffic ----------------
        for (int c = 0; c < 400; c++) begin
            if (!if_req || g_if) begin
                if_req  = ($urandom_range(0, 9) < 6);
                if_addr = AW'($urandom_range(0, 255));
            end
            if (!d_req || g_d) begin
                d_req   = ($urandom_range(0, 9) < 5);
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = AW'($urandom_range(0, 255));
                d_wdata = 8'($urandom);
                d_lock  = ($urandom_range(0, 9) < 3);
            end
            cycle_check();
        end
        nbad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) nbad++;
        check("rand_mem_final", nbad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_imem_port_arbiter

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares the single byte-wide, async-read/sync-write memory port between two requesters:
  - instruction fetch stage: read-only, one byte per beat;
  - data unit: LMAR/IMAR-driven loads and stores, optional locked multi-byte bursts.
- Sits between `fetch` and the data unit on one side and the memory on the other.
- Data has priority; a bounded-hold counter guarantees fetch forward progress.

Parameters:
- AW, 16, address width.
- DATA_MAX, 4, max consecutive unlocked data beats while fetch is waiting (≥1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch requests a read beat
- if_addr  in  AW  fetch byte address
- if_gnt  out  1  fetch beat accepted this cycle
- if_rdata  out  8  read data to fetch
- d_req  in  1  data unit requests a beat
- d_we  in  1  1 = write, 0 = read
- d_addr  in  AW  data byte address
- d_wdata  in  8  write data
- d_lock  in  1  hold ownership across beats (multi-byte burst)
- d_gnt  out  1  data beat accepted this cycle
- d_rdata  out  8  read data to data unit
- mem_addr  out  AW  memory address
- mem_wdata  out  8  memory write data
- mem_we  out  1  memory write enable (sampled at posedge)
- mem_rdata  in  8  async memory read data
- owner_d  out  1  current owner (0 = fetch, 1 = data)

Behaviour:
- State: `owner` register (OWN_IF / OWN_D) plus hold counter `cnt`, width clog2(DATA_MAX)+1, saturating.
- Reset (async, rst_n = 0):
  - owner = OWN_IF, cnt = 0.
  - Consequently d_gnt = 0, mem_we = 0, owner_d = 0, and if_gnt = if_req.
- Grants are combinational from the registered owner:
  - if_gnt = if_req & (owner == OWN_IF)
  - d_gnt = d_req & (owner == OWN_D)
  - A beat completes at the posedge where req & gnt; the requester holds req/addr/wdata stable until granted.
- Memory mux:
  - mem_addr = owner ? d_addr : if_addr
  - mem_wdata = d_wdata
  - mem_we = d_gnt & d_we
  - if_rdata = d_rdata = mem_rdata, valid only in the granted cycle.
- Next-owner rules, evaluated at each posedge:
  - OWN_IF:
    - d_req → OWN_D, cnt = 0. The fetch beat in the current cycle, if any, still completes.
    - otherwise stay OWN_IF.
  - OWN_D:
    - d_req & d_lock → stay OWN_D; cnt increments (saturating). The lock overrides DATA_MAX.
    - d_req & !d_lock & if_req & cnt ≥ DATA_MAX-1 → OWN_IF. Fetch gets at least one beat before data reclaims.
    - d_req otherwise → stay OWN_D, cnt++.
    - !d_req & if_req → OWN_IF.
    - !d_req & !if_req → stay OWN_D, cnt = 0 (parked).
- Ownership switch costs:
  - When the owner is idle and the other side requests, there is exactly one bubble cycle (no grant).
  - No bubble when the owner is busy (the switch coincides with the owner's last beat).
- Simultaneous if_req & d_req while OWN_IF: the fetch beat is granted this cycle and data owns next cycle.
- d_lock is ignored while OWN_IF; lock only holds ownership once granted.
- Reset mid-burst:
  - Grants drop immediately and mem_we = 0 asynchronously.
  - No partial write occurs after rst_n falls.
- Writes never reach the fetch requester; fetch is read-only and if_rdata does not depend on d_we.

Decomposition:
- Shared package (`arb_pkg`): OWN_IF / OWN_D encodings and the default DATA_MAX.
- One sub-module, `arb_hold_ctr`: saturating counter with clear/inc inputs and a ≥ threshold output.
- Owner FSM and mux stay in `imem_port_arbiter`.

Test Plan:
- Reset: rst_n = 0, then release; if_req = 1, if_addr = 0x0003 → if_gnt = 1, d_gnt = 0, mem_addr = 0x0003, owner_d = 0, mem_we = 0.
- Priority/switch:
  - Stimulus: fetch streaming 0x0080.., d_req read at 0x1A2B asserted.
  - Cycle N: if_gnt = 1.
  - Cycle N+1: owner_d = 1, d_gnt = 1, mem_addr = 0x1A2B, d_rdata = imem[0x1A2B], if_gnt = 0.
- Starvation bound: DATA_MAX = 4, d_req continuously (unlocked), if_req continuously → pattern of 4 d_gnt, 1 if_gnt, repeating; no more than 4 consecutive d_gnt.
- Locked burst: d_lock = 1 for 6 write beats to 0x0010..0x0015, if_req = 1 → 6 consecutive d_gnt with mem_we = 1; memory updated; the if_gnt beat follows immediately after lock drops.
- Idle bubble: OWN_D parked (d_req = 0), if_req rises → exactly one cycle with if_gnt = 0, then if_gnt = 1, owner_d = 0.
- Async reset mid-write: d_we = 1 granted; rst_n falls 3 ns after posedge → within 2 ns mem_we = 0, d_gnt = 0, owner_d = 0; target byte unchanged.
